// File: rtl/alu_issue_ctrl.sv
// Issue stage and result capture for the 16-bit ALU: operand register file, single-command
// valid/ready front end, write-back with Z/N/C flags and a valid/ready response.
module alu_issue_ctrl #(
   parameter int W    = 16,
   parameter int NREG = 4,
   localparam int AW  = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ld_en,
   input  logic [AW-1:0] ld_addr,
   input  logic [W-1:0]  ld_data,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    cmd_op,
   input  logic [AW-1:0] cmd_ra,
   input  logic [AW-1:0] cmd_rb,
   input  logic [AW-1:0] cmd_rd,
   input  logic          cmd_cin,
   input  logic          cmd_usec,
   output logic [W-1:0]  alu_a,
   output logic [W-1:0]  alu_b,
   output logic          alu_cin,
   output logic [2:0]    alu_sel,
   input  logic [W-1:0]  alu_sum,
   input  logic          alu_cout,
   output logic          resp_valid,
   input  logic          resp_ready,
   output logic [W-1:0]  resp_data,
   output logic          flag_z,
   output logic          flag_n,
   output logic          flag_c,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);

   typedef enum logic [1:0] {IDLE, ISSUE, WB, RESP} state_t;

   state_t        state;
   logic [W-1:0]  rf [NREG];
   logic [AW-1:0] dst;

   // A pending load steals the IDLE cycle, so the command waits one cycle and sees the new value.
   assign cmd_ready = (state == IDLE) && !ld_en && !rst;
   assign rd_data   = rf[rd_addr];

   // The alu_* registers double as the operand latches; they hold their value until the next accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
         dst        <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_cin    <= 1'b0;
         alu_sel    <= 3'd0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         flag_z     <= 1'b0;
         flag_n     <= 1'b0;
         flag_c     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ld_en) begin
                  rf[ld_addr] <= ld_data;
               end else if (cmd_valid) begin
                  alu_a   <= rf[cmd_ra];
                  alu_b   <= rf[cmd_rb];
                  alu_sel <= cmd_op;
                  alu_cin <= cmd_usec ? flag_c : cmd_cin;
                  dst     <= cmd_rd;
                  state   <= ISSUE;
               end
            end
            ISSUE: state <= WB;
            WB: begin
               rf[dst]    <= alu_sum;
               resp_data  <= alu_sum;
               flag_z     <= (alu_sum == '0);
               flag_n     <= alu_sum[W-1];
               if (!alu_sel[2]) flag_c <= alu_cout;
               resp_valid <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU plus a register/flag reference model, directed
// scenarios followed by randomized commands.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        ldEn;
   logic [1:0]  ldAddr;
   logic [15:0] ldData;
   logic        cmdValid;
   logic        cmdReady;
   logic [2:0]  cmdOp;
   logic [1:0]  cmdRa;
   logic [1:0]  cmdRb;
   logic [1:0]  cmdRd;
   logic        cmdCin;
   logic        cmdUsec;
   logic [15:0] aluA;
   logic [15:0] aluB;
   logic        aluCin;
   logic [2:0]  aluSel;
   logic [15:0] aluSum;
   logic        aluCout;
   logic        respValid;
   logic        respReady;
   logic [15:0] respData;
   logic        flagZ;
   logic        flagN;
   logic        flagC;
   logic [1:0]  rdAddr;
   logic [15:0] rdData;

   int checks = 0;
   int errors = 0;

   logic [15:0] modelRf [4];
   logic        modelZ;
   logic        modelN;
   logic        modelC;

   alu_issue_ctrl dut (
      .clk(clk), .rst(rst),
      .ld_en(ldEn), .ld_addr(ldAddr), .ld_data(ldData),
      .cmd_valid(cmdValid), .cmd_ready(cmdReady), .cmd_op(cmdOp),
      .cmd_ra(cmdRa), .cmd_rb(cmdRb), .cmd_rd(cmdRd), .cmd_cin(cmdCin), .cmd_usec(cmdUsec),
      .alu_a(aluA), .alu_b(aluB), .alu_cin(aluCin), .alu_sel(aluSel),
      .alu_sum(aluSum), .alu_cout(aluCout),
      .resp_valid(respValid), .resp_ready(respReady), .resp_data(respData),
      .flag_z(flagZ), .flag_n(flagN), .flag_c(flagC),
      .rd_addr(rdAddr), .rd_data(rdData)
   );

   always #5 clk = ~clk;

   // ALU ops: 0 ADD, 1 SUB (A+~B+1), 2 INC, 3 DEC, 4 AND, 5 OR, 6 XOR, 7 NOT A; result is {cout, sum}.
   function automatic logic [16:0] aluRef(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic cin);
      case (op)
         3'd0:    return {1'b0, a} + {1'b0, b} + {16'd0, cin};
         3'd1:    return {1'b0, a} + {1'b0, ~b} + 17'd1;
         3'd2:    return {1'b0, a} + 17'd1;
         3'd3:    return {1'b0, a} + 17'h0FFFF;
         3'd4:    return {1'b0, a & b};
         3'd5:    return {1'b0, a | b};
         3'd6:    return {1'b0, a ^ b};
         default: return {1'b0, ~a};
      endcase
   endfunction

   always_comb {aluCout, aluSum} = aluRef(aluSel, aluA, aluB, aluCin);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 4; i++) modelRf[i] = 16'h0000;
      modelZ = 1'b0;
      modelN = 1'b0;
      modelC = 1'b0;
   endtask

   task automatic loadReg(input logic [1:0] addr, input logic [15:0] data);
      ldEn   = 1'b1;
      ldAddr = addr;
      ldData = data;
      tick();
      ldEn   = 1'b0;
      modelRf[addr] = data;
   endtask

   // Issues one command and follows it through ISSUE, WB and RESP, holding off resp_ready for respDelay cycles.
   task automatic applyStimulus(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb,
                                input logic [1:0] rd, input logic cin, input logic usec, input int respDelay);
      logic [15:0] expA;
      logic [15:0] expB;
      logic        expCin;
      logic [16:0] res;
      expA   = modelRf[ra];
      expB   = modelRf[rb];
      expCin = usec ? modelC : cin;
      res    = aluRef(op, expA, expB, expCin);
      modelRf[rd] = res[15:0];
      modelZ = (res[15:0] == 16'h0000);
      modelN = res[15];
      if (!op[2]) modelC = res[16];

      cmdValid = 1'b1;
      cmdOp    = op;
      cmdRa    = ra;
      cmdRb    = rb;
      cmdRd    = rd;
      cmdCin   = cin;
      cmdUsec  = usec;
      rdAddr   = rd;
      #1;
      checkOutput("idle_ready", cmdReady, 1);
      tick();
      cmdValid = 1'b0;
      checkOutput("issue_a", aluA, expA);
      checkOutput("issue_b", aluB, expB);
      checkOutput("issue_sel", aluSel, op);
      checkOutput("issue_cin", aluCin, expCin);
      checkOutput("issue_ready", cmdReady, 0);
      checkOutput("issue_valid", respValid, 0);
      tick();
      checkOutput("wb_valid", respValid, 0);
      checkOutput("wb_ready", cmdReady, 0);
      tick();
      checkOutput("resp_valid", respValid, 1);
      checkOutput("resp_data", respData, res[15:0]);
      checkOutput("flag_z", flagZ, modelZ);
      checkOutput("flag_n", flagN, modelN);
      checkOutput("flag_c", flagC, modelC);
      checkOutput("rf_wb", rdData, res[15:0]);
      for (int i = 0; i < respDelay; i++) begin
         tick();
         checkOutput("bp_valid", respValid, 1);
         checkOutput("bp_data", respData, res[15:0]);
         checkOutput("bp_ready", cmdReady, 0);
      end
      respReady = 1'b1;
      tick();
      respReady = 1'b0;
      checkOutput("post_valid", respValid, 0);
      checkOutput("post_ready", cmdReady, 1);
   endtask

   initial begin
      rst = 1'b1; ldEn = 1'b0; ldAddr = 2'd0; ldData = 16'h0000;
      cmdValid = 1'b0; cmdOp = 3'd0; cmdRa = 2'd0; cmdRb = 2'd0; cmdRd = 2'd0;
      cmdCin = 1'b0; cmdUsec = 1'b0; respReady = 1'b0; rdAddr = 2'd0;
      modelReset();

      tick();
      tick();
      checkOutput("rst_ready", cmdReady, 0);
      checkOutput("rst_valid", respValid, 0);
      checkOutput("rst_data", respData, 0);
      checkOutput("rst_alu_a", aluA, 0);
      checkOutput("rst_alu_b", aluB, 0);
      checkOutput("rst_alu_sel", aluSel, 0);
      checkOutput("rst_alu_cin", aluCin, 0);
      checkOutput("rst_flags", {flagZ, flagN, flagC}, 0);
      for (int i = 0; i < 4; i++) begin
         rdAddr = 2'(i);
         #1;
         checkOutput("rst_rf", rdData, 0);
      end
      rst = 1'b0;
      #1;
      checkOutput("rst_release_ready", cmdReady, 1);

      $display("[TB] directed arithmetic and logic");
      loadReg(2'd0, 16'hAAAA);
      loadReg(2'd1, 16'h5555);
      applyStimulus(3'd0, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 0);
      applyStimulus(3'd1, 2'd0, 2'd1, 2'd3, 1'b0, 1'b0, 5);
      applyStimulus(3'd4, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 0);
      checkOutput("and_keeps_c", flagC, 1);

      $display("[TB] wrap and carry chaining");
      loadReg(2'd0, 16'hFFFF);
      applyStimulus(3'd2, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1);
      checkOutput("inc_wrap", {flagZ, flagC}, 2'b11);
      loadReg(2'd1, 16'h0001);
      loadReg(2'd2, 16'h0000);
      applyStimulus(3'd0, 2'd1, 2'd2, 2'd3, 1'b0, 1'b1, 0);
      checkOutput("usec_sum", respData, 16'h0002);

      $display("[TB] load beats command");
      ldEn = 1'b1; ldAddr = 2'd3; ldData = 16'h1234;
      cmdValid = 1'b1; cmdOp = 3'd5; cmdRa = 2'd3; cmdRb = 2'd1; cmdRd = 2'd2;
      cmdCin = 1'b0; cmdUsec = 1'b0;
      #1;
      checkOutput("ld_stall_ready", cmdReady, 0);
      tick();
      ldEn = 1'b0;
      modelRf[3] = 16'h1234;
      applyStimulus(3'd5, 2'd3, 2'd1, 2'd2, 1'b0, 1'b0, 0);

      $display("[TB] reset during write-back");
      loadReg(2'd0, 16'h0F0F);
      loadReg(2'd1, 16'h0101);
      cmdValid = 1'b1; cmdOp = 3'd0; cmdRa = 2'd0; cmdRb = 2'd1; cmdRd = 2'd2;
      cmdCin = 1'b1; cmdUsec = 1'b0; rdAddr = 2'd2;
      tick();
      cmdValid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      modelReset();
      checkOutput("mid_rst_valid", respValid, 0);
      checkOutput("mid_rst_rf", rdData, 0);
      checkOutput("mid_rst_data", respData, 0);
      checkOutput("mid_rst_alu", {aluA, aluB}, 0);
      checkOutput("mid_rst_ctl", {aluSel, aluCin}, 0);
      checkOutput("mid_rst_flags", {flagZ, flagN, flagC}, 0);
      checkOutput("mid_rst_ready", cmdReady, 0);
      rst = 1'b0;
      #1;
      checkOutput("mid_rst_idle", cmdReady, 1);
      tick();
      checkOutput("mid_rst_no_resp", respValid, 0);

      $display("[TB] randomized commands");
      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 1) == 1)
            loadReg(2'($urandom_range(0, 3)), 16'($urandom));
         applyStimulus(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
